// File: rtl/muldiv_controller.sv
// Iterative 32x32 multiply / divide sequencer (shift-add, restoring divide).
// Define MULDIV_SIGNED_EN to add signed operands via a one-cycle FIX state.
module muldiv_controller (
    input  logic        CLK,
    input  logic        rst,
    input  logic        start,
    input  logic        op_div,
    input  logic        signed_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [2:0]  st
);

`ifdef MULDIV_SIGNED_EN
    localparam bit SGN_EN = 1'b1;
`else
    localparam bit SGN_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state;
    logic [63:0] acc;
    logic [31:0] opb;
    logic [5:0]  cnt;
    logic        is_div;
    logic        is_sgn;
    logic        neg_q;
    logic        neg_r;
    logic        dbz;

    logic        sgn_req;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] mul_sum;
    logic [33:0] div_diff;
    logic        last;
    state_t      fin;

    always_comb begin
        sgn_req  = SGN_EN && signed_op;
        abs_a    = (sgn_req && a[31]) ? -a : a;
        abs_b    = (sgn_req && b[31]) ? -b : b;
        mul_sum  = {1'b0, acc[63:32]} + {1'b0, opb};
        // 34 bits: the shifted remainder can reach 33 bits before subtracting
        div_diff = {1'b0, acc[63:31]} - {2'b00, opb};
        last     = (cnt == 6'd31);
        fin      = is_sgn ? FIX : DONE;
        busy     = (state != IDLE);
        st       = state;
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            opb         <= '0;
            cnt         <= '0;
            is_div      <= 1'b0;
            is_sgn      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dbz         <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cnt    <= '0;
                        is_div <= op_div;
                        is_sgn <= sgn_req;
                        neg_q  <= sgn_req && (a[31] ^ b[31]);
                        neg_r  <= sgn_req && a[31];
                        dbz    <= 1'b0;
                        if (op_div && b == 32'd0) begin
                            acc   <= {a, 32'hFFFF_FFFF};
                            opb   <= b;
                            dbz   <= 1'b1;
                            state <= DONE;
                        end else if (op_div) begin
                            acc   <= {32'd0, abs_a};
                            opb   <= abs_b;
                            state <= DIV;
                        end else begin
                            acc   <= {32'd0, abs_b};
                            opb   <= abs_a;
                            state <= MUL;
                        end
                    end
                end
                MUL: begin
                    if (acc[0])
                        acc <= {mul_sum, acc[31:1]};
                    else
                        acc <= {1'b0, acc[63:1]};
                    cnt <= cnt + 6'd1;
                    if (last)
                        state <= fin;
                end
                DIV: begin
                    if (!div_diff[33])
                        acc <= {div_diff[31:0], acc[30:0], 1'b1};
                    else
                        acc <= {acc[62:0], 1'b0};
                    cnt <= cnt + 6'd1;
                    if (last)
                        state <= fin;
                end
                FIX: begin
                    if (!is_div) begin
                        if (neg_q)
                            acc <= -acc;
                    end else begin
                        acc[63:32] <= neg_r ? -acc[63:32] : acc[63:32];
                        acc[31:0]  <= neg_q ? -acc[31:0] : acc[31:0];
                    end
                    state <= DONE;
                end
                DONE: begin
                    hi          <= acc[63:32];
                    lo          <= acc[31:0];
                    div_by_zero <= dbz;
                    done        <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_controller.sv
// Bench for muldiv_controller: directed corner cases plus random operations
// compared against an arithmetic reference model.
module tb_muldiv_controller;

`ifdef MULDIV_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        rst;
    logic        start;
    logic        op_div;
    logic        signed_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [2:0]  st;

    int checks = 0;
    int failures = 0;

    muldiv_controller dut (
        .CLK(CLK),
        .rst(rst),
        .start(start),
        .op_div(op_div),
        .signed_op(signed_op),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .div_by_zero(div_by_zero),
        .hi(hi),
        .lo(lo),
        .st(st)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on the operands.
    task automatic ref_op(input bit od, input bit sg,
                          input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] eh, output logic [31:0] el,
                          output bit ez, output int lat);
        bit          s;
        logic [63:0] p;
        longint      px;
        longint      py;
        longint      q;
        longint      r;
        s  = SGN && sg;
        px = longint'($signed(x));
        py = longint'($signed(y));
        if (od && y == 32'd0) begin
            eh  = x;
            el  = 32'hFFFF_FFFF;
            ez  = 1'b1;
            lat = 1;
        end else begin
            ez  = 1'b0;
            lat = s ? 34 : 33;
            if (!od) begin
                if (s)
                    p = 64'(px * py);
                else
                    p = {32'd0, x} * {32'd0, y};
                eh = p[63:32];
                el = p[31:0];
            end else if (s) begin
                q  = px / py;
                r  = px % py;
                el = q[31:0];
                eh = r[31:0];
            end else begin
                el = x / y;
                eh = x % y;
            end
        end
    endtask

    task automatic run(input string tag, input bit od, input bit sg,
                       input logic [31:0] x, input logic [31:0] y,
                       input int poke);
        logic [31:0] eh;
        logic [31:0] el;
        logic [31:0] ph;
        logic [31:0] pl;
        bit          ez;
        bit          got;
        int          lat;
        int          k;
        int          bc;
        ref_op(od, sg, x, y, eh, el, ez, lat);
        @(negedge CLK);
        ph        = hi;
        pl        = lo;
        start     = 1'b1;
        op_div    = od;
        signed_op = sg;
        a         = x;
        b         = y;
        @(posedge CLK);
        #1;
        start     = 1'b0;
        a         = $urandom;
        b         = $urandom;
        op_div    = 1'($urandom);
        signed_op = 1'($urandom);
        k   = 0;
        bc  = 0;
        got = 1'b0;
        while (!got && k < 60) begin
            @(negedge CLK);
            start = (k == poke);
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy)
                    bc++;
                if (k == 10)
                    chk({tag, "_hold"}, {hi, lo}, {ph, pl});
                k++;
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 64'(got), 64'd1);
        chk({tag, "_latency"}, 64'(k), 64'(lat));
        chk({tag, "_busy_cycles"}, 64'(bc), 64'(lat));
        chk({tag, "_hi"}, 64'(hi), 64'(eh));
        chk({tag, "_lo"}, 64'(lo), 64'(el));
        chk({tag, "_dbz"}, 64'(div_by_zero), 64'(ez));
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        @(negedge CLK);
        chk({tag, "_pulse"}, {62'd0, done, busy}, 64'd0);
        chk({tag, "_held"}, {hi, lo}, {eh, el});
    endtask

    initial begin
        int ndone;
        rst       = 1'b1;
        start     = 1'b0;
        op_div    = 1'b0;
        signed_op = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_st", 64'(st), 64'd0);
        rst = 1'b0;

        run("mul6x7", 1'b0, 1'b0, 32'd6, 32'd7, -1);
        run("mulmax", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        run("div100_7", 1'b1, 1'b0, 32'd100, 32'd7, -1);
        run("div55_0", 1'b1, 1'b0, 32'd55, 32'd0, -1);
        run("start_in_mul", 1'b0, 1'b0, 32'd6, 32'd7, 5);
        run("start_in_done", 1'b0, 1'b0, 32'd123, 32'd456, 32);
        run("smul", 1'b0, 1'b1, 32'hFFFF_FFFA, 32'd7, -1);
        run("sdiv", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, -1);
        run("sdiv0", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd0, -1);

        // Abort a multiply mid-flight; rst also beats a concurrent start.
        @(negedge CLK);
        start  = 1'b1;
        op_div = 1'b0;
        a      = 32'd9;
        b      = 32'd9;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (10) @(negedge CLK);
        chk("abort_busy_before", 64'(busy), 64'd1);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge CLK);
        chk("abort_st", 64'(st), 64'd0);
        chk("abort_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        @(negedge CLK);
        chk("rst_over_start", 64'(busy), 64'd0);
        rst   = 1'b0;
        start = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge CLK);
            if (done)
                ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);

        for (int i = 0; i < 20; i++) begin
            logic [31:0] x;
            logic [31:0] y;
            bit          od;
            bit          sg;
            od = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            x  = $urandom;
            case ($urandom_range(0, 3))
                0:       y = 32'd0;
                1:       y = $urandom_range(1, 15);
                default: y = $urandom;
            endcase
            run($sformatf("rnd%0d", i), od, sg, x, y, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
